// File: rtl/y86_pkg.sv
// Shared definitions for the instruction prefetch path: instruction and
// memory-word sizes, the request FSM state encoding, and a helper that
// checks whether a consume length is legal.
package y86_pkg;

    localparam int MAX_INSTR_LEN = 10;
    localparam int WORD_BYTES    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ERR  = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    // A pop length is legal when it is 1..MAX_INSTR_LEN bytes.
    function automatic logic len_in_range(input logic [3:0] len);
        return (len != 4'd0) && (len <= 4'(MAX_INSTR_LEN));
    endfunction

endpackage

// File: rtl/fetch_prefetch_buf_byte_queue.sv
// Circular byte store. Accepts one memory word per cycle starting at a byte
// offset within the word, pops up to MAX_INSTR_LEN bytes per cycle, and
// exposes the oldest MAX_INSTR_LEN bytes as a window. Bytes past the fill
// level read as zero. Callers guarantee a push never exceeds free space.
module byte_queue
    import y86_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push_en,
    input  logic [63:0]            push_data,
    input  logic [2:0]             push_skip,
    input  logic                   pop_en,
    input  logic [3:0]             pop_len,
    output logic [$clog2(DEPTH):0] count,
    output logic [79:0]            window
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic             push_go;
    logic [3:0]       push_n;
    logic [3:0]       pop_n;
    logic [7:0]       lane_en;
    logic [PTR_W-1:0] lane_idx [WORD_BYTES];

    assign push_go = push_en && !flush;
    assign push_n  = push_go ? (4'd8 - {1'b0, push_skip}) : 4'd0;
    assign pop_n   = (pop_en && !flush) ? pop_len : 4'd0;
    assign count   = count_reg;

    // Byte lane gi of the incoming word lands at wr_ptr + (gi - skip);
    // lanes below the skip offset belong to the previous instruction stream.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign lane_en[gi]  = push_go && (3'(gi) >= push_skip);
            assign lane_idx[gi] = wr_ptr_reg + PTR_W'(gi) - PTR_W'(push_skip);
        end
    endgenerate

    // Read window: byte gi is valid only while it lies below the fill level.
    generate
        for (genvar gi = 0; gi < MAX_INSTR_LEN; gi++) begin : g_win
            logic [PTR_W-1:0] rd_idx;
            assign rd_idx = rd_ptr_reg + PTR_W'(gi);
            assign window[8*gi +: 8] = (CNT_W'(gi) < count_reg) ? mem_reg[rd_idx] : 8'h00;
        end
    endgenerate

    // Pointer and fill-level arithmetic; a flush empties the queue outright.
    always_comb begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(push_n);
        rd_ptr_next = rd_ptr_reg + PTR_W'(pop_n);
        count_next  = count_reg + CNT_W'(push_n) - CNT_W'(pop_n);
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Byte storage; contents need no reset because the window masks by count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (lane_en[i]) begin
                mem_reg[lane_idx[i]] <= push_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/fetch_prefetch_buf.sv
// Instruction prefetch queue. Fetches aligned 8-byte words from instruction
// memory ahead of decode, presents a 10-byte window at ins_pc, pops decoded
// instruction lengths, and restarts cleanly on a PC redirect. A memory fault
// freezes fetching until the next redirect.
module fetch_prefetch_buf
    import y86_pkg::*;
#(
    parameter int          DEPTH    = 32,
    parameter logic [63:0] RESET_PC = 64'd32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [63:0] imem_rdata,
    input  logic        imem_err,
    output logic        ins_valid,
    output logic [63:0] ins_pc,
    output logic [79:0] ins_bytes,
    output logic        ins_err,
    input  logic        ins_consume,
    input  logic [3:0]  ins_len
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    // Highest fill level that still leaves room for a whole word.
    localparam logic [CNT_W-1:0] ROOM_LIMIT = CNT_W'(DEPTH - WORD_BYTES);

    fetch_state_t     state_reg, state_next;
    logic [63:0]      fetch_addr_reg, fetch_addr_next;
    logic [2:0]       skip_reg, skip_next;
    logic [63:0]      ins_pc_reg, ins_pc_next;
    logic             imem_req_reg, imem_req_next;
    logic [63:0]      imem_addr_reg, imem_addr_next;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after_push;
    logic             push_en;
    logic             pop_en;
    logic             in_err;

    assign in_err           = (state_reg == ST_ERR);
    assign ins_valid        = (count >= CNT_W'(MAX_INSTR_LEN)) || in_err;
    assign ins_err          = in_err && (count < CNT_W'(MAX_INSTR_LEN));
    assign ins_pc           = ins_pc_reg;
    assign imem_req         = imem_req_reg;
    assign imem_addr        = imem_addr_reg;

    // Data is accepted only for a live request; a redirect discards it.
    assign push_en          = (state_reg == ST_REQ) && imem_ack && !imem_err && !redirect_valid;
    // Illegal lengths, or lengths past the fill level, are ignored.
    assign pop_en           = ins_valid && ins_consume && len_in_range(ins_len) &&
                              (CNT_W'(ins_len) <= count) && !redirect_valid;
    // Room check after a push uses the pre-consume level, so pushes always fit.
    assign count_after_push = count + CNT_W'(4'd8 - {1'b0, skip_reg});

    byte_queue #(
        .DEPTH(DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push_en   (push_en),
        .push_data (imem_rdata),
        .push_skip (skip_reg),
        .pop_en    (pop_en),
        .pop_len   (ins_len),
        .count     (count),
        .window    (ins_bytes)
    );

    // Request FSM, fetch address tracking and consumed-PC update.
    always_comb begin
        state_next      = state_reg;
        fetch_addr_next = fetch_addr_reg;
        skip_next       = skip_reg;
        ins_pc_next     = ins_pc_reg;

        if (redirect_valid) begin
            fetch_addr_next = {redirect_pc[63:3], 3'b000};
            skip_next       = redirect_pc[2:0];
            ins_pc_next     = redirect_pc;
            // An unanswered request must still be drained before reissuing.
            if ((state_reg == ST_REQ || state_reg == ST_DROP) && !imem_ack) begin
                state_next = ST_DROP;
            end else begin
                state_next = ST_REQ;
            end
        end else begin
            if (pop_en) begin
                ins_pc_next = ins_pc_reg + {60'd0, ins_len};
            end
            case (state_reg)
                ST_IDLE: begin
                    if (count <= ROOM_LIMIT) begin
                        state_next = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        if (imem_err) begin
                            state_next = ST_ERR;
                        end else begin
                            fetch_addr_next = fetch_addr_reg + 64'd8;
                            skip_next       = 3'd0;
                            state_next      = (count_after_push <= ROOM_LIMIT) ? ST_REQ : ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (imem_ack) begin
                        state_next = ST_REQ;
                    end
                end
                default: begin
                    state_next = state_reg;
                end
            endcase
        end

        // A fresh request presents fetch_addr; a draining one keeps the old address.
        imem_req_next  = (state_next == ST_REQ) || (state_next == ST_DROP);
        imem_addr_next = (state_next == ST_REQ) ? fetch_addr_next : imem_addr_reg;
    end

    // State and registered memory-interface outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            fetch_addr_reg <= {RESET_PC[63:3], 3'b000};
            skip_reg       <= RESET_PC[2:0];
            ins_pc_reg     <= RESET_PC;
            imem_req_reg   <= 1'b0;
            imem_addr_reg  <= {RESET_PC[63:3], 3'b000};
        end else begin
            state_reg      <= state_next;
            fetch_addr_reg <= fetch_addr_next;
            skip_reg       <= skip_next;
            ins_pc_reg     <= ins_pc_next;
            imem_req_reg   <= imem_req_next;
            imem_addr_reg  <= imem_addr_next;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buf.sv
// Bench for the prefetch queue: behavioural instruction memory (byte value =
// low address byte, optional stall and fault address), directed stimulus
// that queues expected windows and request addresses, and monitors that
// compare against those queues as the DUT presents them.
module tb_fetch_prefetch_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [63:0] imem_rdata = 64'd0;
    logic        imem_err = 1'b0;
    logic        ins_valid;
    logic [63:0] ins_pc;
    logic [79:0] ins_bytes;
    logic        ins_err;
    logic        ins_consume = 1'b0;
    logic [3:0]  ins_len = 4'd0;

    fetch_prefetch_buf #(
        .DEPTH    (32),
        .RESET_PC (64'd32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .imem_err       (imem_err),
        .ins_valid      (ins_valid),
        .ins_pc         (ins_pc),
        .ins_bytes      (ins_bytes),
        .ins_err        (ins_err),
        .ins_consume    (ins_consume),
        .ins_len        (ins_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [79:0] bytes;
        logic        err;
    } win_t;

    win_t        exp_win[$];
    logic [63:0] exp_req[$];

    int          total = 0;
    int          bad = 0;
    int          mem_stall = 0;
    int          wait_cnt = 0;
    logic [63:0] err_addr = '1;

    function automatic logic [63:0] word_at(input logic [63:0] a);
        logic [63:0] w;
        logic [63:0] b;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            b = a + 64'(k);
            w[8*k +: 8] = b[7:0];
        end
        return w;
    endfunction

    function automatic logic [79:0] window_at(input logic [63:0] pc);
        logic [79:0] w;
        logic [63:0] b;
        w = '0;
        for (int k = 0; k < 10; k++) begin
            b = pc + 64'(k);
            w[8*k +: 8] = b[7:0];
        end
        return w;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Instruction memory: answers at +1 after the edge, so a zero-stall
    // memory acks in the same cycle the request is seen.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && imem_req) begin
                if (wait_cnt >= mem_stall) begin
                    imem_ack   = 1'b1;
                    imem_err   = (imem_addr == err_addr);
                    imem_rdata = word_at(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    imem_ack = 1'b0;
                    imem_err = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                imem_err = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: compare each consumed window and each answered request.
    initial begin
        win_t        w;
        logic [63:0] a;
        forever begin
            @(posedge clk);
            #4;
            if (rst_n && ins_valid && ins_consume) begin
                if (exp_win.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_consume: got pc %h want no consume", ins_pc);
                end else begin
                    w = exp_win.pop_front();
                    $display("consume pc=%h len=%0d bytes=%h err=%b", ins_pc, ins_len, ins_bytes, ins_err);
                    check("win_pc", 80'(ins_pc), 80'(w.pc));
                    check("win_bytes", ins_bytes, w.bytes);
                    check("win_err", 80'(ins_err), 80'(w.err));
                end
            end
            if (rst_n && imem_req && imem_ack && exp_req.size() > 0) begin
                a = exp_req.pop_front();
                $display("request addr=%h err=%b", imem_addr, imem_err);
                check("req_addr", 80'(imem_addr), 80'(a));
            end
        end
    end

    task automatic consume(input logic [3:0] len, input logic [63:0] pc,
                           input logic [79:0] bytes, input logic err);
        int   n;
        win_t w;
        n = 0;
        while (!ins_valid && n < 60) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (!ins_valid) begin
            total++;
            bad++;
            $display("FAIL consume_timeout: got ins_valid=0 want 1 for pc %h", pc);
        end else begin
            w.pc    = pc;
            w.bytes = bytes;
            w.err   = err;
            exp_win.push_back(w);
            ins_len     = len;
            ins_consume = 1'b1;
            @(posedge clk);
            #2;
            ins_consume = 1'b0;
        end
    endtask

    task automatic redirect(input logic [63:0] pc);
        ins_consume    = 1'b0;
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] pc;

        // 1. Reset values, then first window at RESET_PC.
        repeat (2) @(posedge clk);
        #2;
        check("rst_ins_valid", 80'(ins_valid), 80'd0);
        check("rst_imem_req", 80'(imem_req), 80'd0);
        check("rst_ins_err", 80'(ins_err), 80'd0);
        check("rst_ins_pc", 80'(ins_pc), 80'd32);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("t1_valid_cycle3", 80'(ins_valid), 80'd1);
        check("t1_bytes", ins_bytes, 80'h29282726252423222120);
        consume(4'd10, 64'd32, 80'h29282726252423222120, 1'b0);

        // 2. Back-to-back full-length consumes.
        pc = 64'd42;
        for (int i = 0; i < 20; i++) begin
            consume(4'd10, pc, window_at(pc), 1'b0);
            pc = pc + 64'd10;
        end

        // 3. Redirect to an unaligned pc.
        redirect(64'h45);
        exp_req.push_back(64'h40);
        exp_req.push_back(64'h48);
        exp_req.push_back(64'h50);
        consume(4'd10, 64'h45, 80'h4e4d4c4b4a4948474645, 1'b0);
        check("t3_reqs_left", 80'(exp_req.size()), 80'd0);

        // 4. Redirect while a stalled request is outstanding.
        mem_stall = 3;
        redirect(64'h100);
        exp_req.push_back(64'h100);
        exp_req.push_back(64'h200);
        exp_req.push_back(64'h208);
        check("t4_req_up", 80'(imem_req), 80'd1);
        check("t4_addr_first", 80'(imem_addr), 80'h100);
        @(posedge clk);
        #2;
        redirect(64'h203);
        check("t4_addr_held", 80'(imem_addr), 80'h100);
        check("t4_req_held", 80'(imem_req), 80'd1);
        check("t4_valid_flushed", 80'(ins_valid), 80'd0);
        consume(4'd10, 64'h203, 80'h0c0b0a09080706050403, 1'b0);
        check("t4_reqs_left", 80'(exp_req.size()), 80'd0);

        // 5. Memory fault on the second word.
        mem_stall = 0;
        repeat (2) @(posedge clk);
        #2;
        err_addr = 64'h48;
        redirect(64'h40);
        exp_req.push_back(64'h40);
        exp_req.push_back(64'h48);
        consume(4'd3, 64'h40, 80'h00004746454443424140, 1'b1);
        consume(4'd5, 64'h43, 80'h00000000004746454443, 1'b1);
        check("t5_valid_empty", 80'(ins_valid), 80'd1);
        check("t5_err_empty", 80'(ins_err), 80'd1);
        check("t5_bytes_empty", ins_bytes, 80'd0);
        check("t5_pc_empty", 80'(ins_pc), 80'h48);
        check("t5_no_req", 80'(imem_req), 80'd0);
        check("t5_reqs_left", 80'(exp_req.size()), 80'd0);
        err_addr = '1;
        redirect(64'h80);
        check("t5_err_cleared", 80'(ins_err), 80'd0);
        check("t5_valid_cleared", 80'(ins_valid), 80'd0);
        consume(4'd10, 64'h80, 80'h89888786858483828180, 1'b0);

        // 6. Asynchronous reset in the middle of a stalled request.
        mem_stall = 3;
        redirect(64'hc0);
        check("t6_req_up", 80'(imem_req), 80'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_req_drop", 80'(imem_req), 80'd0);
        check("t6_valid_rst", 80'(ins_valid), 80'd0);
        check("t6_err_rst", 80'(ins_err), 80'd0);
        check("t6_pc_rst", 80'(ins_pc), 80'd32);
        mem_stall = 0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        consume(4'd10, 64'd32, 80'h29282726252423222120, 1'b0);
        check("windows_left", 80'(exp_win.size()), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
